// File: rtl/cmp_seq_ctrl_pkg.sv
// Shared constants for the nibble-serial compare controller:
// condition encodings, FSM states and the cascade slice width.
package cmp_pkg;

    localparam int SLICE_W = 4;

    localparam logic [2:0] COND_EQ     = 3'd0;
    localparam logic [2:0] COND_NE     = 3'd1;
    localparam logic [2:0] COND_LT     = 3'd2;
    localparam logic [2:0] COND_GE     = 3'd3;
    localparam logic [2:0] COND_GT     = 3'd4;
    localparam logic [2:0] COND_LE     = 3'd5;
    localparam logic [2:0] COND_ALWAYS = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic cond_eval(input logic [2:0] cond,
                                       input logic lt, input logic eq, input logic gt);
        logic r;
        r = 1'b0;
        case (cond)
            COND_EQ:     r = eq;
            COND_NE:     r = ~eq;
            COND_LT:     r = lt;
            COND_GE:     r = ~lt;
            COND_GT:     r = gt;
            COND_LE:     r = ~gt;
            COND_ALWAYS: r = 1'b1;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_seq_ctrl_if.sv
// Request/response bundle between a requester (master) and the compare controller (slave).
interface cmp_seq_ctrl_if #(parameter int WIDTH = 16);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             is_signed;
    logic [2:0]       cond;
    logic             flush;
    logic             resp_valid;
    logic             resp_ready;
    logic             lt;
    logic             eq;
    logic             gt;
    logic             taken;
    logic             busy;

    modport master (
        output req_valid, op_a, op_b, is_signed, cond, flush, resp_ready,
        input  req_ready, resp_valid, lt, eq, gt, taken, busy
    );

    modport slave (
        input  req_valid, op_a, op_b, is_signed, cond, flush, resp_ready,
        output req_ready, resp_valid, lt, eq, gt, taken, busy
    );
endinterface

// File: rtl/cmp_seq_ctrl_nibble_cmp.sv
// Combinational 4-bit magnitude-compare cascade slice; a differing nibble
// decides lt/gt, an equal nibble passes the lower-order result through.
import cmp_pkg::*;

module nibble_cmp (
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               lt_i,
    input  logic               eq_i,
    input  logic               gt_i,
    output logic               lt_o,
    output logic               eq_o,
    output logic               gt_o
);
    always_comb begin
        lt_o = lt_i;
        eq_o = eq_i;
        gt_o = gt_i;
        if (a_i < b_i) begin
            lt_o = 1'b1;
            eq_o = 1'b0;
            gt_o = 1'b0;
        end else if (a_i > b_i) begin
            lt_o = 1'b0;
            eq_o = 1'b0;
            gt_o = 1'b1;
        end
    end
endmodule

// File: rtl/cmp_seq_ctrl.sv
// Sequential comparator: walks the operands one nibble per cycle LSB-first
// through a single cascade slice, then holds the result until consumed.
import cmp_pkg::*;

module cmp_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    cmp_seq_ctrl_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IW     = $clog2(NSLICE);
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       cond_q, cond_d;
    logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
    logic             s_lt, s_eq, s_gt;
    logic             accept;

    assign bus.req_ready  = (state_q == ST_IDLE) && !bus.flush;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.resp_valid = (state_q == ST_DONE);
    assign bus.lt         = lt_q;
    assign bus.eq         = eq_q;
    assign bus.gt         = gt_q;
    assign bus.taken      = cond_eval(cond_q, lt_q, eq_q, gt_q);

    nibble_cmp u_slice (
        .a_i  (a_q[idx_q*SLICE_W +: SLICE_W]),
        .b_i  (b_q[idx_q*SLICE_W +: SLICE_W]),
        .lt_i (lt_q),
        .eq_i (eq_q),
        .gt_i (gt_q),
        .lt_o (s_lt),
        .eq_o (s_eq),
        .gt_o (s_gt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        cond_d  = cond_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Flipping the sign bit maps two's-complement order onto unsigned order.
                    a_d     = bus.op_a ^ {bus.is_signed, {(WIDTH-1){1'b0}}};
                    b_d     = bus.op_b ^ {bus.is_signed, {(WIDTH-1){1'b0}}};
                    cond_d  = bus.cond;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    lt_d = s_lt;
                    eq_d = s_eq;
                    gt_d = s_gt;
                    if (idx_q == LAST) state_d = ST_DONE;
                    else               idx_d   = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.flush || bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b1;
            gt_q    <= 1'b0;
            cond_q  <= COND_EQ;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            cond_q  <= cond_d;
        end
    end

    // Operand latches carry no reset; they are only read after an accept.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Randomized self-checking bench for cmp_seq_ctrl against an integer-compare model.
module tb_cmp_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cmp_seq_ctrl_if #(.WIDTH(16)) bus ();

    cmp_seq_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {lt,eq,gt,taken} from plain integer comparison.
    function automatic logic [3:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic s, input logic [2:0] c);
        int ia, ib;
        logic l, e, g, t;
        ia = s ? int'($signed(a)) : int'({16'h0, a});
        ib = s ? int'($signed(b)) : int'({16'h0, b});
        l = (ia < ib);
        e = (ia == ib);
        g = (ia > ib);
        case (c)
            3'd0: t = e;
            3'd1: t = !e;
            3'd2: t = l;
            3'd3: t = (ia >= ib);
            3'd4: t = g;
            3'd5: t = (ia <= ib);
            3'd6: t = 1'b1;
            default: t = 1'b0;
        endcase
        return {l, e, g, t};
    endfunction

    function automatic logic [3:0] obs();
        return {bus.lt, bus.eq, bus.gt, bus.taken};
    endfunction

    task automatic scramble();
        bus.op_a      = 16'($urandom);
        bus.op_b      = 16'($urandom);
        bus.is_signed = 1'($urandom);
        bus.cond      = 3'($urandom);
    endtask

    // Offer one request, accept it, return after the accept edge (+1).
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [2:0] c);
        @(negedge clk);
        chk("req_ready_idle", bus.req_ready, 1'b1);
        bus.op_a = a; bus.op_b = b; bus.is_signed = s; bus.cond = c;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [2:0] c, input int hold);
        int lat;
        logic [3:0] exp;
        exp = model(a, b, s, c);
        issue(a, b, s, c);
        wait_resp(lat);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_flags"}, obs(), exp);
        chk({tag, "_onehot"}, 32'(bus.lt + bus.eq + bus.gt), 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            scramble();
            chk({tag, "_hold_flags"}, obs(), exp);
            chk({tag, "_hold_rv"}, bus.resp_valid, 1'b1);
            chk({tag, "_hold_rdy"}, bus.req_ready, 1'b0);
            chk({tag, "_hold_busy"}, bus.busy, 1'b1);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk({tag, "_idle_busy"}, bus.busy, 1'b0);
        chk({tag, "_idle_rv"}, bus.resp_valid, 1'b0);
    endtask

    initial begin
        int seen;
        int lat;
        logic s;
        bus.req_valid = 1'b0; bus.resp_ready = 1'b0; bus.flush = 1'b0;
        scramble();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", bus.req_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rv", bus.resp_valid, 1'b0);
        chk("rst_flags", {bus.lt, bus.eq, bus.gt}, 3'b010);
        rst_n = 1'b1;

        // Directed cases
        run_op("ult",   16'h1234, 16'h1235, 1'b0, 3'd2, 0);
        run_op("sgt",   16'hFFFF, 16'h0001, 1'b1, 3'd4, 0);
        run_op("ugt",   16'hFFFF, 16'h0001, 1'b0, 3'd4, 0);
        run_op("eq",    16'hABCD, 16'hABCD, 1'b0, 3'd0, 0);
        run_op("le",    16'hABCE, 16'hABCD, 1'b0, 3'd5, 0);
        run_op("bp",    16'h8000, 16'h7FFF, 1'b1, 3'd3, 5);
        run_op("hinib", 16'h1FFF, 16'h2000, 1'b0, 3'd2, 1);

        // Flush while RUN at idx=2
        issue(16'h0001, 16'h0002, 1'b0, 3'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_run_busy", bus.busy, 1'b0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) seen++;
        end
        chk("flush_run_noresp", seen, 0);

        // req_valid with flush in IDLE is not accepted
        @(negedge clk);
        bus.req_valid = 1'b1; bus.flush = 1'b1;
        #1 chk("flush_idle_rdy", bus.req_ready, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        chk("flush_idle_busy", bus.busy, 1'b0);

        // Flush in DONE drops the result
        issue(16'h4444, 16'h4444, 1'b0, 3'd0);
        wait_resp(lat);
        chk("flush_done_lat", lat, 4);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_done_rv", bus.resp_valid, 1'b0);
        chk("flush_done_busy", bus.busy, 1'b0);

        // Reset in DONE with resp_ready low
        issue(16'h0010, 16'h0001, 1'b0, 3'd4);
        wait_resp(lat);
        chk("rst_done_lat", lat, 4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_done_rv", bus.resp_valid, 1'b0);
        chk("rst_done_eq", {bus.lt, bus.eq, bus.gt}, 3'b010);
        chk("rst_done_rdy", bus.req_ready, 1'b1);
        rst_n = 1'b1;

        // Random sweep, biased toward near-equal operands half the time
        for (int i = 0; i < 60; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = (i % 2 == 0) ? 16'($urandom) : (a ^ (16'h1 << $urandom_range(0, 15)));
            if (i % 7 == 0) b = a;
            s = 1'($urandom);
            run_op("rand", a, b, s, 3'($urandom), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/cmp_seq_ctrl.md
CMP_SEQ_CTRL -- requirements
Module: cmp_seq_ctrl

Interface
REQ-001 Parameter WIDTH, 16, operand width; SHALL be a multiple of 4, minimum 8.
REQ-002 Parameter NSLICE, WIDTH/4, nibble steps per compare; SHALL be derived, not overridden.
REQ-003 One clock and one reset; reset is synchronous and active-low; ports SHALL be: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-004 Ports SHALL be:
- req_valid  in  1  operation offered.
- req_ready  out  1  controller can accept.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- is_signed  in  1  two's-complement compare when 1.
- cond  in  3  condition: 0 EQ, 1 NE, 2 LT, 3 GE, 4 GT, 5 LE, 6 ALWAYS, 7 NEVER.
- flush  in  1  abort in-flight operation.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- lt, eq, gt  out  1 each  A<B, A==B, A>B.
- taken  out  1  cond evaluated on flags.
- busy  out  1  state is not IDLE.

Function
REQ-010 FSM states SHALL be IDLE, RUN, DONE.
REQ-011 req_ready SHALL be 1 only in IDLE with flush=0; accept = req_valid & req_ready.
REQ-012 On accept: latch op_a, op_b, cond; if is_signed, invert bit WIDTH-1 of both latched operands; load cascade flags {lt,eq,gt}={0,1,0}; idx=0; go RUN.
REQ-013 Each RUN cycle SHALL compare nibble idx of the latched operands, LSB nibble first, through one 4-bit cascade slice fed by the registered flags, then register the slice outputs and increment idx.
REQ-014 Slice rule: a nibble difference decides lt/gt; equal nibbles SHALL pass the incoming flags through; eq is high only if the nibble and the incoming eq are both equal.
REQ-015 When idx=NSLICE-1 in RUN, the next state SHALL be DONE. resp_valid rises exactly NSLICE cycles after the accept edge (4 for WIDTH=16).
REQ-016 In DONE, resp_valid=1 and lt/eq/gt/taken SHALL be stable until resp_ready=1. On resp_ready=1, go to IDLE. A new request cannot be accepted in the same cycle, so throughput is one per NSLICE+2 cycles.
REQ-017 taken SHALL be combinational from the registered flags and latched cond per REQ-004; it is valid only while resp_valid=1.
REQ-018 Exactly one of lt/eq/gt SHALL be high whenever resp_valid=1.
REQ-019 flush=1 in RUN or DONE SHALL go to IDLE next cycle with no response; a pending result in DONE is dropped.
REQ-020 flush=1 in IDLE SHALL block acceptance; req_valid with flush in the same cycle is not accepted.
REQ-021 Inputs op_a, op_b, is_signed and cond SHALL be ignored outside the accept cycle.
REQ-022 busy SHALL be 1 in RUN and DONE.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE, idx=0, lt=0, eq=1, gt=0, resp_valid=0; reset SHALL override flush and accept.
REQ-031 After reset, req_ready=1 and busy=0; taken is don't-care while resp_valid=0.
REQ-032 Reset during RUN or DONE SHALL abandon the operation with no response.

Structure
REQ-040 Shared package cmp_pkg SHALL hold: the cond encoding localparams, the FSM state enum, and the slice width constant 4.
REQ-041 One sub-module, nibble_cmp, SHALL implement the combinational 4-bit cascade slice of REQ-014; the controller SHALL instantiate it exactly once.
REQ-042 The idx counter SHALL be $clog2(NSLICE) bits wide and SHALL not wrap within an operation.

Verification
REQ-050 Unsigned: A=0x1234, B=0x1235, cond=LT -> resp_valid 4 cycles after accept; lt=1, eq=0, gt=0, taken=1.
REQ-051 Signed: A=0xFFFF, B=0x0001, is_signed=1, cond=GT -> lt=1, taken=0. Same operands unsigned -> gt=1, taken=1.
REQ-052 Equal with a low-nibble-only difference: A=0xABCD, B=0xABCD, cond=EQ -> eq=1, taken=1. Then A=0xABCE, B=0xABCD, cond=LE -> gt=1, taken=0.
REQ-053 Backpressure: resp_ready held 0 for 5 cycles -> flags and taken stable, req_ready=0, busy=1; first resp_ready=1 -> IDLE next cycle.
REQ-054 Flush at RUN idx=2 -> IDLE next cycle, no resp_valid; req_valid and flush together in IDLE -> not accepted.
REQ-055 rst_n=0 in DONE with resp_ready=0 -> next cycle resp_valid=0, eq=1, req_ready=1; random 16-bit signed/unsigned sweep checked against a reference model.
